vga_timing_out: RTL and testbench

// - Final VGA stage: generates 640x480@60 raster timing, publishes pixelX/pixelY to sprite/bitmap logic,

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_timing_out_sync_delay_line.sv | 39 +++
 rtl/vga_timing_out.sv | 136 +++++++++++++
 tb/tb_vga_timing_out.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// VGA raster constants and colour helpers shared by the timing stage and by
// the bitmap/sprite blocks that work in pixel coordinates.
package vga_pkg;

    // 640x480@60 horizontal timing, in pixels
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // 640x480@60 vertical timing, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync windows (inclusive) for the default timing
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    // Colour produced by the object priority mux
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Colour driven onto the 4:4:4 DAC
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Widen by replicating the top bits so full scale stays full scale (FF -> FFF)
    function automatic rgb444_t rgb332_to_444(input rgb332_t c);
        rgb444_t o;
        o.r = {c.r, c.r[2]};
        o.g = {c.g, c.g[2]};
        o.b = {c.b, c.b};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing_out_sync_delay_line.sv
// Enable-gated shift register used to line up sync/blank with the colour
// pipeline. DEPTH=0 degenerates to a wire.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift one stage per enable; reset loads every stage with RESET_VAL
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else if (en) begin
                    stage_q[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// Final VGA stage: raster counters, sync/blank decode delayed to match the
// pixel pipeline, colour expansion and the registered DAC/sync outputs.
// There is no FSM: all state is the divider, the counters, the delay line
// and the output registers.
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CLK_DIV  = 2,   // clk cycles per pixel, 1..8
    parameter int RGB_LAT  = 1    // pixel ticks from pixelX/Y to matching RGBIn, 0..4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGBIn,
    output logic        pixEn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB,
    output logic        hsyncN,
    output logic        vsyncN,
    output logic        blankN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);

    logic [2:0] div_q;
    logic [2:0] div_next;
    logic       act_raw, hs_raw, vs_raw;
    logic       act_d, hs_d, vs_d;
    logic [2:0] dl_q;
    rgb444_t    colour;

    // Next divider value; wraps at CLK_DIV-1
    always_comb begin
        div_next = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
    end

    // Divider and pixel tick; pixEn is registered so it is high exactly
    // while the divider sits at its last value
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= 3'd0;
            pixEn <= 1'b0;
        end else begin
            div_q <= div_next;
            pixEn <= (div_next == DIV_LAST);
        end
    end

    // Raster counters advance once per pixel tick
    always_ff @(posedge clk) begin
        if (reset) begin
            pixelX <= 11'd0;
            pixelY <= 11'd0;
        end else if (pixEn) begin
            if (pixelX == H_LAST) begin
                pixelX <= 11'd0;
                pixelY <= (pixelY == V_LAST) ? 11'd0 : pixelY + 11'd1;
            end else begin
                pixelX <= pixelX + 11'd1;
            end
        end
    end

    // Frame tick: coincides with the first clk that shows (0,0)
    always_ff @(posedge clk) begin
        if (reset) begin
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= pixEn && (pixelX == H_LAST) && (pixelY == V_LAST);
        end
    end

    // Raw decode from the live counters
    assign act_raw = (pixelX < H_ACT) && (pixelY < V_ACT);
    assign hs_raw  = (pixelX >= HS_FIRST) && (pixelX <= HS_LAST);
    assign vs_raw  = (pixelY >= VS_FIRST) && (pixelY <= VS_LAST);

    // Hold sync/blank back by the colour latency; reset content is
    // {sync inactive, blanked}
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (RGB_LAT),
        .RESET_VAL (3'b000)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en    (pixEn),
        .d     ({hs_raw, vs_raw, act_raw}),
        .q     (dl_q)
    );

    assign {hs_d, vs_d, act_d} = dl_q;
    assign colour = rgb332_to_444(rgb332_t'(RGBIn));

    // Output registers: sample colour and delayed syncs on the pixel tick only
    always_ff @(posedge clk) begin
        if (reset) begin
            hsyncN <= 1'b1;
            vsyncN <= 1'b1;
            blankN <= 1'b0;
            vgaR   <= 4'd0;
            vgaG   <= 4'd0;
            vgaB   <= 4'd0;
        end else if (pixEn) begin
            hsyncN <= ~hs_d;
            vsyncN <= ~vs_d;
            blankN <= act_d;
            vgaR   <= act_d ? colour.r : 4'd0;
            vgaG   <= act_d ? colour.g : 4'd0;
            vgaB   <= act_d ? colour.b : 4'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out. Horizontal timing is the real 640x480 line; the
// vertical timing is shortened (4 active lines, 8 total) so several whole
// frames fit in a short run. Expected outputs come from a tick-count model:
// after c clks since reset, k = c/CLK_DIV ticks have elapsed, the counters
// are k mod H_TOTAL etc., and the output registers show the pixel from
// RGB_LAT ticks before the last tick with the RGBIn sampled on that tick.
module tb_vga_timing_out;

    localparam int D   = 2;
    localparam int LAT = 1;
    localparam int HA  = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA  = 4,   VF = 1,  VS = 2,  VB = 1;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;

    // clock / reset
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  RGBIn = 8'd0;
    logic        pixEn;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame;
    logic [3:0]  vgaR, vgaG, vgaB;
    logic        hsyncN, vsyncN, blankN;

    always #10 clk = ~clk;

    vga_timing_out #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CLK_DIV  (D),  .RGB_LAT (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RGBIn        (RGBIn),
        .pixEn        (pixEn),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .vgaR         (vgaR),
        .vgaG         (vgaG),
        .vgaB         (vgaB),
        .hsyncN       (hsyncN),
        .vsyncN       (vsyncN),
        .blankN       (blankN)
    );

    // scoreboard state
    int         n_pass = 0;
    int         n_chk  = 0;
    int         c = 0;
    int         cyc = 0;
    int         mx = 0, my = 0;
    bit         started = 0;
    logic [7:0] rgb_hist [int];
    int         mode = 0;          // 0 random, 1 mux model, 2 constant
    logic [7:0] const_val = 8'd0;
    int         last_sof = -1;
    int         n_sof = 0;
    logic       prev_hn = 1'b1, prev_vn = 1'b1;
    int         hs_run = 0;
    bit         hs_seen = 0;

    function automatic logic [11:0] exp444(input logic [7:0] v);
        return {v[7:5], v[7], v[4:2], v[4], v[1:0], v[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // One clk: advance the model, compare at negedge, drive next RGBIn
    task automatic step();
        int k, t, src, sx, sy;
        logic e_pix, e_sof, e_hn, e_vn, e_bn;
        logic [11:0] e_rgb;
        @(posedge clk);
        cyc++;
        if (reset) begin
            c = 0;
            rgb_hist.delete();
            last_sof = -1;
            n_sof = 0;
            prev_hn = 1'b1;
            prev_vn = 1'b1;
            hs_run = 0;
            hs_seen = 0;
            started = 1;
        end else begin
            c++;
        end
        @(negedge clk);
        k  = c / D;
        mx = k % HT;
        my = (k / HT) % VT;
        if (started) begin
            e_pix = (c % D == D - 1);
            e_sof = (k > 0) && (k % (HT * VT) == 0) && (c % D == 0);
            e_hn = 1'b1; e_vn = 1'b1; e_bn = 1'b0; e_rgb = 12'd0;
            if (k - 1 - LAT >= 0) begin
                t  = k - 1;
                src = t - LAT;
                sx = src % HT;
                sy = (src / HT) % VT;
                e_bn = (sx < HA) && (sy < VA);
                e_hn = !((sx >= HA + HF) && (sx < HA + HF + HS));
                e_vn = !((sy >= VA + VF) && (sy < VA + VF + VS));
                if (e_bn) e_rgb = exp444(rgb_hist[t]);
            end
            chk("pixEn",  32'(pixEn), 32'(e_pix));
            chk("pixelX", 32'(pixelX), 32'(mx));
            chk("pixelY", 32'(pixelY), 32'(my));
            chk("sof",    32'(startOfFrame), 32'(e_sof));
            chk("hsyncN", 32'(hsyncN), 32'(e_hn));
            chk("vsyncN", 32'(vsyncN), 32'(e_vn));
            chk("blankN", 32'(blankN), 32'(e_bn));
            chk("rgb",    32'({vgaR, vgaG, vgaB}), 32'(e_rgb));

            if (startOfFrame === 1'b1) begin
                if (last_sof >= 0) chk("sof_gap", 32'(cyc - last_sof), 32'(HT * VT * D));
                last_sof = cyc;
                n_sof++;
            end
            if (prev_hn === 1'b1 && hsyncN === 1'b0) begin
                chk("hs_fall_x", 32'(pixelX), 32'(HA + HF + LAT + 1));
                hs_seen = 1;
                hs_run = 0;
            end
            if (hsyncN === 1'b0) hs_run++;
            if (prev_hn === 1'b0 && hsyncN === 1'b1 && hs_seen) begin
                chk("hs_low_clks", 32'(hs_run), 32'(HS * D));
            end
            if (prev_vn === 1'b1 && vsyncN === 1'b0) begin
                chk("vs_fall_xy", 32'({pixelX, pixelY}), 32'({11'(LAT + 1), 11'(VA + VF)}));
            end
            prev_hn = hsyncN;
            prev_vn = vsyncN;
        end
        // driver: real colour on tick clks, garbage in between
        if (c % D == D - 1) begin
            case (mode)
                1:       RGBIn = (k - LAT >= 0) ? 8'((k - LAT) % HT) : 8'd0;
                2:       RGBIn = const_val;
                default: RGBIn = 8'($urandom);
            endcase
            rgb_hist[k] = RGBIn;
        end else begin
            RGBIn = 8'($urandom_range(0, 255));
        end
    endtask

    // Step until the model shows pixel x on an active line, bounded by one frame
    task automatic run_until(input int x);
        bit hit;
        hit = 0;
        for (int i = 0; i < HT * VT * D + 4; i++) begin
            step();
            if (c % D == 0 && mx == x && my < VA) begin
                hit = 1;
                break;
            end
        end
        chk("run_until", 32'(hit), 32'd1);
    endtask

    task automatic directed(input string tag, input logic [7:0] v, input logic [11:0] e_rgb);
        mode = 2;
        const_val = v;
        repeat (8) step();
        run_until(100);
        chk(tag, 32'({vgaR, vgaG, vgaB}), 32'(e_rgb));
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rel_c1_x", 32'(pixelX), 32'd0);
        chk("rel_c1_pixEn", 32'(pixEn), 32'd1);
        step();
        chk("rel_c2_x", 32'(pixelX), 32'd1);

        // mid-line reset at pixelX=300
        mode = 0;
        run_until(300);
        reset = 1'b1;
        repeat (5) begin
            step();
            chk("rst_x",   32'(pixelX), 32'd0);
            chk("rst_y",   32'(pixelY), 32'd0);
            chk("rst_pix", 32'(pixEn), 32'd0);
            chk("rst_sof", 32'(startOfFrame), 32'd0);
            chk("rst_hn",  32'(hsyncN), 32'd1);
            chk("rst_vn",  32'(vsyncN), 32'd1);
            chk("rst_bn",  32'(blankN), 32'd0);
            chk("rst_rgb", 32'({vgaR, vgaG, vgaB}), 32'd0);
        end
        reset = 1'b0;
        step();
        chk("rel2_c1_x", 32'(pixelX), 32'd0);
        step();
        chk("rel2_c2_x", 32'(pixelX), 32'd1);

        // random colours, then the mux model across two frame boundaries
        mode = 0;
        repeat (3000) step();
        mode = 1;
        repeat (23000) step();
        chk("sof_count", 32'(n_sof), 32'd2);

        // colour expansion
        directed("exp_ff", 8'hFF, 12'hFFF);
        directed("exp_00", 8'h00, 12'h000);
        directed("exp_e0", 8'hE0, 12'hF00);
        directed("exp_56", 8'b010_101_10, {4'b0100, 4'b1011, 4'b1010});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
